// File: rtl/ones_comp_checksum.sv
// ones_comp_checksum
//   Accumulates the ones-complement sum of a framed word stream (one word per
//   cycle over a valid/ready handshake) and presents sum + checksum (~sum) on
//   a held result handshake once the last word of the frame is taken.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   in_valid_i / in_ready_o         input word handshake
//   in_data_i [WIDTH]               word to accumulate
//   in_last_i                       final word of the frame
//   out_valid_o / out_ready_i       result handshake (held until consumed)
//   sum_o, checksum_o [WIDTH]       ones-complement sum and its complement
//   word_count_o [CNT_W]            words in the frame, saturating at MAX_WORDS
//   overflow_o                      frame held more than MAX_WORDS words

// Ones-complement adder with end-around carry. The carry fold cannot carry
// out again, and all-ones (negative zero) is passed through untouched.
module ones_comp_add #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);
  logic [WIDTH:0] s;
  assign s   = {1'b0, a_i} + {1'b0, b_i};
  assign y_o = s[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, s[WIDTH]};
endmodule

module ones_comp_checksum #(
  parameter  int WIDTH     = 4,
  parameter  int MAX_WORDS = 15,
  localparam int CNT_W     = $clog2(MAX_WORDS+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic [WIDTH-1:0] checksum_o,
  output logic [CNT_W-1:0] word_count_o,
  output logic             overflow_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_y;

  assign accept = in_valid_i && in_ready_o;

  // A frame's first word is added to zero, so a stale accumulator from the
  // previous frame never leaks into the new one.
  assign add_a = (state_q == IDLE) ? '0 : acc_q;

  ones_comp_add #(.WIDTH(WIDTH)) u_add (
    .a_i (add_a),
    .b_i (in_data_i),
    .y_o (add_y)
  );

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACCUM: if (accept) state_d = in_last_i ? DONE : ACCUM;
      DONE:        if (out_ready_i) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Datapath next-state: accumulator, saturating word counter, overflow flag.
  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (accept) begin
      acc_d = add_y;
      if (state_q == IDLE) begin
        count_d = CNT_W'(1);
        ovf_d   = 1'b0;
      end else if (count_q == CNT_W'(MAX_WORDS)) begin
        // Counter saturates; the frame keeps accumulating, only flagged.
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // ---------------- output logic ----------------
  // Result fields are driven straight from registers and forced to zero
  // outside DONE, so they are stable while held and zero out of reset.
  always_comb begin
    in_ready_o   = (state_q != DONE);
    out_valid_o  = (state_q == DONE);
    sum_o        = '0;
    checksum_o   = '0;
    word_count_o = '0;
    overflow_o   = 1'b0;
    if (state_q == DONE) begin
      sum_o        = acc_q;
      checksum_o   = ~acc_q;
      word_count_o = count_q;
      overflow_o   = ovf_q;
    end
  end

endmodule
